// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic {IDLE, RUN} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], bit_i};
    diff    = shifted - {1'b0, div_i};
    q_o     = (shifted >= {1'b0, div_i});
    rem_o   = q_o ? diff : shifted;
  end

endmodule

// File: rtl/div32x32.sv
// Sequential unsigned divider: one quotient bit per clock, results 32 clocks after start is taken.
module div32x32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // Handshake: start is taken only in IDLE (busy=0); a and b are captured on that edge.
  // busy stays high for the whole run, done pulses one cycle when quotient/remainder update.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (r_q),
    .bit_i (dq_q[WIDTH-1]),
    .div_i (div_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    dq_d    = dq_q;
    r_d     = r_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          div_d   = b;
          dq_d    = a;
          r_d     = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        r_d   = step_rem;
        dq_d  = {dq_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        // Final step writes the visible results directly from the step outputs.
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          quo_d   = {dq_q[WIDTH-2:0], step_bit};
          rem_d   = step_rem[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      dq_q    <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      dq_q    <= dq_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
